// File: rtl/temp_code_to_pulse_if.sv
// Handshake and pulse-train signal bundle for temp_code_to_pulse.
// master drives the code request and stop; slave is the pulse generator.
interface temp_code_to_pulse_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4
);
  logic [WIDTH-1:0] code_in;
  logic [REP_W-1:0] rep_in;
  logic             code_valid;
  logic             code_ready;
  logic             stop;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] periods;

  modport master (
    output code_in, rep_in, code_valid, stop,
    input  code_ready, pulse_out, busy, done, periods
  );

  modport slave (
    input  code_in, rep_in, code_valid, stop,
    output code_ready, pulse_out, busy, done, periods
  );
endinterface

// File: rtl/temp_code_to_pulse.sv
// Temperature code to comparator-style pulse train: max(code,1) low cycles then
// PULSE_LEN high cycles per period, for rep_in periods or until stopped.
module temp_code_to_pulse #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned REP_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  temp_code_to_pulse_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  localparam int unsigned      HW    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [HW-1:0]    HLAST = HW'(PULSE_LEN - 1);
  localparam logic [REP_W-1:0] PSAT  = '1;

  state_t           state, state_n;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] lcnt, lcnt_n;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] periods_q, periods_n;
  logic [HW-1:0]    hcnt, hcnt_n;
  logic             stop_pend, stop_pend_n;
  logic             pulse_q, busy_q, done_q;
  logic             take;
  logic             rep_hit;

  // Low phase lasts max(code,1) cycles, so the down-counter loads L-1.
  function automatic logic [WIDTH-1:0] low_load(input logic [WIDTH-1:0] c);
    return (c == '0) ? '0 : c - WIDTH'(1);
  endfunction

  assign bus.code_ready = (state == IDLE) && !done_q;
  assign take           = bus.code_valid && bus.code_ready;
  assign rep_hit        = (rep_q != '0) && ((periods_q + REP_W'(1)) == rep_q);

  always_comb begin
    state_n     = state;
    lcnt_n      = lcnt;
    hcnt_n      = hcnt;
    periods_n   = periods_q;
    stop_pend_n = stop_pend;
    unique case (state)
      IDLE: begin
        if (take) begin
          state_n     = LOW;
          lcnt_n      = low_load(bus.code_in);
          periods_n   = '0;
          stop_pend_n = 1'b0;
        end
      end
      LOW: begin
        if (bus.stop) stop_pend_n = 1'b1;
        if (lcnt == '0) begin
          state_n = HIGH;
          hcnt_n  = HLAST;
        end else begin
          lcnt_n = lcnt - WIDTH'(1);
        end
      end
      HIGH: begin
        if (bus.stop) stop_pend_n = 1'b1;
        if (hcnt == '0) begin
          if (periods_q != PSAT) periods_n = periods_q + REP_W'(1);
          // A stop seen in this very cycle still ends the train here.
          if (stop_pend || bus.stop || rep_hit) begin
            state_n = IDLE;
          end else begin
            state_n = LOW;
            lcnt_n  = low_load(code_q);
          end
        end else begin
          hcnt_n = hcnt - HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      code_q    <= '0;
      rep_q     <= '0;
      lcnt      <= '0;
      hcnt      <= '0;
      periods_q <= '0;
      stop_pend <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      lcnt      <= lcnt_n;
      hcnt      <= hcnt_n;
      periods_q <= periods_n;
      stop_pend <= stop_pend_n;
      if (take) begin
        code_q <= bus.code_in;
        rep_q  <= bus.rep_in;
      end
      // Outputs are registered from the next state so they line up with it.
      pulse_q <= (state_n == HIGH);
      busy_q  <= (state_n != IDLE);
      done_q  <= (state == HIGH) && (state_n == IDLE);
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.periods   = periods_q;

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> !busy_q);

endmodule

// File: doc/temp_code_to_pulse.md
Name: temp_code_to_pulse

Overview:
Inverse of the temperature digitizer. Takes a WIDTH-bit temperature code and produces a comparator-style pulse train on pulse_out. A cycle counter that clears on the pulse reads that code back. The block serves as the on-chip BIST/calibration stimulus: its output replaces the analog comparator output at the digitizer input, and it doubles as the digital behavioural model of the sensor front end.

Parameters:
WIDTH, 8, width of the temperature code
PULSE_LEN, 2, cycles pulse_out stays high per period (>=1)
REP_W, 4, width of the repeat count and period counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
code_in  input  WIDTH  target temperature code
rep_in  input  REP_W  number of periods to emit; 0 = continuous until stop
code_valid  input  1  code_in/rep_in valid
code_ready  output  1  block can accept a new code
stop  input  1  request graceful stop
pulse_out  output  1  emulated comparator output, registered
busy  output  1  pulse train in progress
done  output  1  one-cycle strobe when the train ends
periods  output  REP_W  completed periods in the current train, saturating

Behaviour:
- Reset (async assert, sync release): state IDLE; pulse_out=0, busy=0, done=0, periods=0, code_ready=1; latched code, repeat and stop_pending cleared. Reset mid-train aborts immediately with no done strobe.
- Handshake: transfer when code_valid && code_ready. code_ready = (state==IDLE) && !done. No back-pressure on pulse_out. code_valid outside IDLE is ignored, not queued.
- On transfer:
  - Latch code_in and rep_in.
  - Clear periods and stop_pending.
  - Next state LOW, busy=1 from the next cycle.
- FSM states: IDLE, LOW, HIGH.
- LOW:
  - pulse_out=0 for L = max(code,1) cycles; code 0 is treated as 1.
  - Down-counter loaded with L-1 on entry.
  - When it reaches 0, go to HIGH.
- HIGH:
  - pulse_out=1 for exactly PULSE_LEN cycles.
  - On the last HIGH cycle, periods increments and saturates at 2^REP_W-1.
  - Leave to IDLE if stop_pending, or stop is asserted this cycle, or (rep!=0 and periods+1==rep). Otherwise go to LOW and reload the counter.
- Period: exactly max(code,1)+PULSE_LEN cycles. The first LOW cycle is the cycle after the handshake cycle.
- stop:
  - Sampled every cycle in LOW/HIGH; sets stop_pending.
  - The current period always completes; the train never truncates mid-pulse.
  - stop in IDLE is ignored. stop in the same cycle as a transfer is ignored.
- done:
  - Asserted for exactly one cycle, the first IDLE cycle after HIGH.
  - busy=0 in that same cycle.
  - code_ready returns the following cycle.
- Arithmetic: unsigned. The code counter is WIDTH bits, with no wrap since it loads at most 2^WIDTH-2. periods compares at REP_W bits.
- Continuous mode (rep=0): runs until stop. periods saturates and does not wrap.
- pulse_out is glitch-free: it comes from a flop and has no combinational path from inputs.

Test Plan:
1. Reset while busy: assert rst_n=0 in the middle of HIGH -> pulse_out, busy and periods go to 0 asynchronously; done never pulses; code_ready=1 after release.
2. Single period: code=5, rep=1, PULSE_LEN=2 -> pulse_out reads 0,0,0,0,0,1,1 starting the cycle after the handshake, then done=1 for one cycle and periods=1. A reference cycle-counter digitizer clearing on pulse_out reads 5.
3. Boundary codes, rep=3:
   - code=0 -> period 3 (1 low + 2 high).
   - code=255 -> period 257.
   - Each run gives 3 periods, then done.
4. Continuous mode: code=10, rep=0, run 20 periods -> periods saturates at 15. Assert stop in the 3rd LOW cycle of period 21 -> the period completes (12 cycles), then done. No extra pulse.
5. Handshake: code_valid held high while busy with a different code -> it is not accepted. After done, code_ready returns one cycle later and the new code is accepted. stop in the same cycle as the handshake -> ignored; the full rep count is emitted.
6. Back-to-back trains: code=3/rep=2, then code=7/rep=1 presented as soon as code_ready rises -> the second train starts on the 2nd cycle after done, with period 9.
